keypad_scanner: RTL
===================

// Module: keypad_scanner
// PURPOSE
//  Input-side counterpart of the multiplexed 7-seg driver: scans a 4x4 hex keypad
//  (Pmod KYPD layout) by strobing columns and reading rows. Debounces the press,
//  reports one key event per press, and shifts the entered digit into a 16-bit value.
//  That value drives the display's number[15:0] input directly.
// PARAMETERS
//  SCAN_DIV_BITS   18  column dwell = 2^SCAN_DIV_BITS clk100 cycles (must be >= 3)
//  DEBOUNCE_SCANS  4   consecutive identical samples to accept a press or release (2..15)
// PORTS
//  clk100     in   1   100 MHz system clock; all state on posedge
//  rst_n      in   1   reset, asynchronous assert, active-low
//  col        out  4   column strobes, active-low one-hot (0 = column driven)
//  row        in   4   row returns, active-low, pulled up, asynchronous to clk100
//  clear      in   1   sync pulse: number <= 0
//  key_code   out  4   hex value of last accepted key, held until next press
//  key_valid  out  1   1-cycle pulse on press acceptance
//  key_down   out  1   high from press acceptance until release is accepted
//  number     out  16  entered digits; newest digit in [3:0]
// BEHAVIOUR
//  Reset values: col=4'b1110, key_code=0, key_valid=0, key_down=0, number=0,
//   divider=0, FSM=SCAN. Reset may assert mid-press; on release the FSM is in SCAN
//   and issues no event for the interrupted press.
//  row passes through a 2-flop synchronizer (rs) before any use.
//  tick: divider wraps at 2^SCAN_DIV_BITS-1; tick is a 1-cycle strobe.
//  Rows are sampled only on tick, i.e. at the end of the dwell, so col is settled.
//  Sample classes: none (rs==4'hF), single (exactly one bit low), multi (anything else).
//  States:
//   SCAN:   tick & single -> DEBOUNCE, latch {col,row} as candidate, cnt=1, hold col.
//           tick & (none|multi) -> rotate col 1110->1101->1011->0111->1110.
//   DEBOUNCE (col held): on tick, a sample equal to the candidate increments cnt.
//           When cnt reaches DEBOUNCE_SCANS -> HELD.
//           Any other sample -> SCAN, col rotates, no event.
//   HELD:   on entry cycle: key_valid=1, key_code=map(candidate), key_down=1,
//           number <= {number[11:0], map(candidate)} (oldest digit discarded).
//           On tick, a none sample increments the release count; anything else
//           resets it to 0. At DEBOUNCE_SCANS -> SCAN, key_down=0, col rotates.
//           Second key pressed while held: ignored (no event).
//  Latency: key_valid is asserted on the cycle after the tick that carries the
//   DEBOUNCE_SCANS-th matching sample.
//  Key map, rows r0..r3 x cols c0..c3: r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C |
//   r3: 0 F E D.
//  clear and key_valid in the same cycle: clear wins (number=0); key_code and
//   key_valid still report the key.
//  Counters saturate, never wrap; cnt width is 4 bits.
// STRUCTURE
//  Package keypad_pkg holds:
//   - state enum SCAN/DEBOUNCE/HELD
//   - COL_INIT=4'b1110
//   - function key_map(input [3:0] col_n, input [3:0] row_n) returning [3:0]
//  Sub-module sync2 (2-flop synchronizer, width param), instantiated on row.
//  Divider, FSM, and number shifter stay in keypad_scanner.
// TESTING (SCAN_DIV_BITS=3, DEBOUNCE_SCANS=3; bench keypad model drives row from col)
//  1. Reset, no key -> col cycles 1110,1101,1011,0111 every 8 clks; key_valid never 1.
//  2. Hold r1c2 ('6') steady -> exactly one key_valid pulse, key_code=6, key_down=1;
//     release -> key_down=0 three ticks after the first all-high sample.
//  3. Press 1,2,3,A,5 (each held then released) -> number sequence
//     0001, 0012, 0123, 123A, 23A5.
//  4. Bounce r0c0: present for 2 ticks, absent, then steady -> no event from the
//     bounce; a single event ('1') once the key is steady.
//  5. r0c1 and r2c1 together (multi) -> no event; key_down stays 0; col keeps rotating.
//  6. clear pulsed in the key_valid cycle -> number=0000 and key_code valid; assert
//     rst_n low in HELD -> all outputs take their reset values asynchronously.

Source files
------------

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared types and helpers for the 4x4 hex keypad scanner.
//                Holds the scanner state encoding, the initial column strobe
//                pattern and the {column,row} -> hex key map.
//  Revision    : 1.0  initial release
// ============================================================================
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    // Column 0 driven first after reset (strobes are active-low).
    localparam logic [3:0] COL_INIT = 4'b1110;

    // Translate an active-low one-hot column strobe and row return into the
    // hex legend printed on the key.
    function automatic logic [3:0] key_map(input logic [3:0] col_n,
                                           input logic [3:0] row_n);
        logic [1:0] c;
        logic [1:0] r;
        logic [3:0] code;
        case (col_n)
            4'b1110: c = 2'd0;
            4'b1101: c = 2'd1;
            4'b1011: c = 2'd2;
            4'b0111: c = 2'd3;
            default: c = 2'd0;
        endcase
        case (row_n)
            4'b1110: r = 2'd0;
            4'b1101: r = 2'd1;
            4'b1011: r = 2'd2;
            4'b0111: r = 2'd3;
            default: r = 2'd0;
        endcase
        case ({r, c})
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'h0;
            4'd13:   code = 4'hF;
            4'd14:   code = 4'hE;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : sync2
//  Description : Two-flop synchronizer for a bus of independent asynchronous
//                level signals. Each bit is synchronized on its own; no
//                coherency between bits is implied.
//  Ports       : clk    - destination clock
//                rst_n  - asynchronous active-low reset
//                i_d    - asynchronous input bus
//                o_q    - synchronized output bus
//  Revision    : 1.0  initial release
// ============================================================================
module sync2 #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta_q;
    logic [WIDTH-1:0] r_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta_q <= RESET_VAL;
            r_sync_q <= RESET_VAL;
        end else begin
            r_meta_q <= i_d;
            r_sync_q <= r_meta_q;
        end
    end

    assign o_q = r_sync_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner
//  Description : Scans a 4x4 hex keypad by strobing columns (active-low) and
//                reading rows, debounces presses and releases, emits one
//                key_valid pulse per press and shifts each new digit into a
//                16-bit value (newest digit in [3:0]).
//  Ports       : clk100    - system clock
//                rst_n     - asynchronous active-low reset
//                col       - column strobes, active-low one-hot
//                row       - row returns, active-low, asynchronous
//                clear     - synchronous clear of number
//                key_code  - hex value of last accepted key
//                key_valid - one-cycle pulse on press acceptance
//                key_down  - high while an accepted key is held
//                number    - entered digits
//  Revision    : 1.0  initial release
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV_BITS  = 18,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk100,
    input  logic        rst_n,
    output logic [3:0]  col,
    input  logic [3:0]  row,
    input  logic        clear,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_down,
    output logic [15:0] number
);

    localparam logic [3:0] c_debounce_target = 4'(DEBOUNCE_SCANS);
    localparam logic [SCAN_DIV_BITS-1:0] c_div_one = {{(SCAN_DIV_BITS-1){1'b0}}, 1'b1};

    logic [SCAN_DIV_BITS-1:0] r_div_q, w_div_d;
    state_t                   r_state_q, w_state_d;
    logic [3:0]               r_col_q, w_col_d;
    logic [3:0]               r_cand_q, w_cand_d;
    logic [3:0]               r_cnt_q, w_cnt_d;
    logic [3:0]               r_key_code_q, w_key_code_d;
    logic                     r_key_valid_q, w_key_valid_d;
    logic                     r_key_down_q, w_key_down_d;
    logic [15:0]              r_number_q, w_number_d;

    logic [3:0] w_rs;
    logic       w_tick;
    logic       w_none;
    logic       w_single;
    logic [3:0] w_col_rot;
    logic [3:0] w_cnt_inc;

    sync2 #(
        .WIDTH     (4),
        .RESET_VAL (4'hF)
    ) u_row_sync (
        .clk   (clk100),
        .rst_n (rst_n),
        .i_d   (row),
        .o_q   (w_rs)
    );

    // The tick lands on the last cycle of each dwell, so the rows seen at
    // the tick have had the full dwell to settle behind the current column.
    assign w_tick    = &r_div_q;
    assign w_none    = (w_rs == 4'hF);
    assign w_col_rot = {r_col_q[2:0], r_col_q[3]};
    assign w_cnt_inc = (r_cnt_q == 4'hF) ? r_cnt_q : r_cnt_q + 4'd1;

    always_comb begin
        case (w_rs)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: w_single = 1'b1;
            default:                            w_single = 1'b0;
        endcase
    end

    always_comb begin
        w_div_d       = r_div_q + c_div_one;
        w_state_d     = r_state_q;
        w_col_d       = r_col_q;
        w_cand_d      = r_cand_q;
        w_cnt_d       = r_cnt_q;
        w_key_code_d  = r_key_code_q;
        w_key_valid_d = 1'b0;
        w_key_down_d  = r_key_down_q;

        case (r_state_q)
            SCAN: begin
                if (w_tick) begin
                    if (w_single) begin
                        w_state_d = DEBOUNCE;
                        w_cand_d  = w_rs;
                        w_cnt_d   = 4'd1;
                    end else begin
                        w_col_d = w_col_rot;
                    end
                end
            end
            DEBOUNCE: begin
                if (w_tick) begin
                    if (w_rs == r_cand_q) begin
                        w_cnt_d = w_cnt_inc;
                        if (w_cnt_inc >= c_debounce_target) begin
                            w_state_d     = HELD;
                            w_cnt_d       = 4'd0;
                            w_key_valid_d = 1'b1;
                            w_key_code_d  = key_map(r_col_q, r_cand_q);
                            w_key_down_d  = 1'b1;
                        end
                    end else begin
                        w_state_d = SCAN;
                        w_col_d   = w_col_rot;
                    end
                end
            end
            HELD: begin
                // Column stays parked on the pressed key; any activity on it
                // (including a second key) restarts the release count.
                if (w_tick) begin
                    if (w_none) begin
                        w_cnt_d = w_cnt_inc;
                        if (w_cnt_inc >= c_debounce_target) begin
                            w_state_d    = SCAN;
                            w_cnt_d      = 4'd0;
                            w_key_down_d = 1'b0;
                            w_col_d      = w_col_rot;
                        end
                    end else begin
                        w_cnt_d = 4'd0;
                    end
                end
            end
            default: begin
                w_state_d = SCAN;
                w_col_d   = COL_INIT;
                w_cnt_d   = 4'd0;
            end
        endcase
    end

    // The digit is shifted in at the end of the key_valid cycle so that a
    // clear arriving in that same cycle takes precedence over the new digit.
    always_comb begin
        w_number_d = r_number_q;
        if (clear) begin
            w_number_d = 16'h0000;
        end else if (r_key_valid_q) begin
            w_number_d = {r_number_q[11:0], r_key_code_q};
        end
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            r_div_q       <= '0;
            r_state_q     <= SCAN;
            r_col_q       <= COL_INIT;
            r_cand_q      <= 4'hF;
            r_cnt_q       <= 4'd0;
            r_key_code_q  <= 4'h0;
            r_key_valid_q <= 1'b0;
            r_key_down_q  <= 1'b0;
            r_number_q    <= 16'h0000;
        end else begin
            r_div_q       <= w_div_d;
            r_state_q     <= w_state_d;
            r_col_q       <= w_col_d;
            r_cand_q      <= w_cand_d;
            r_cnt_q       <= w_cnt_d;
            r_key_code_q  <= w_key_code_d;
            r_key_valid_q <= w_key_valid_d;
            r_key_down_q  <= w_key_down_d;
            r_number_q    <= w_number_d;
        end
    end

    assign col       = r_col_q;
    assign key_code  = r_key_code_q;
    assign key_valid = r_key_valid_q;
    assign key_down  = r_key_down_q;
    assign number    = r_number_q;

endmodule
`default_nettype wire
